// File: rtl/time_entry_ctrl_if.sv
// Keypad/time-entry bus between the key decoder side and time_entry_ctrl.
// master: drives start/cur_*/key/nav strobes; slave: drives hour/minute/second/twinkle/status.
interface time_entry_ctrl_if;
   logic       start;
   logic [5:0] cur_hour;
   logic [5:0] cur_minute;
   logic [5:0] cur_second;
   logic       key_valid;
   logic [3:0] key_val;
   logic       next;
   logic       back;
   logic       abort;
   logic [5:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic [2:0] twinkle;
   logic       busy;
   logic       done;
   logic       err;
   logic       timeout;

   modport master (
      output start, cur_hour, cur_minute, cur_second,
      output key_valid, key_val, next, back, abort,
      input  hour, minute, second, twinkle,
      input  busy, done, err, timeout
   );

   modport slave (
      input  start, cur_hour, cur_minute, cur_second,
      input  key_valid, key_val, next, back, abort,
      output hour, minute, second, twinkle,
      output busy, done, err, timeout
   );
endinterface

// File: rtl/time_entry_ctrl.sv
// Digit-by-digit hh:mm[:ss] time-entry controller with cursor, range check, abort, commit.
// Ports: clk, rst (sync, active-high), bus (time_entry_ctrl_if.slave).
// Optional macro TIME_ENTRY_TIMEOUT_EN adds an inactivity auto-abort.
module time_entry_ctrl #(
   parameter int NUM_FIELDS     = 2,
   parameter int HOUR_MAX       = 23,
   parameter int MIN_MAX        = 59,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input logic              clk,
   input logic              rst,
   time_entry_ctrl_if.slave bus
);
   localparam logic [2:0] LAST = 3'(2 * NUM_FIELDS - 1);

   typedef enum logic {IDLE, EDIT} state_t;

   state_t     state, state_n;
   logic [2:0] cur, cur_n;
   logic [3:0] tens    [0:2];
   logic [3:0] units   [0:2];
   logic [3:0] tens_n  [0:2];
   logic [3:0] units_n [0:2];
   logic [3:0] snap_t  [0:2];
   logic [3:0] snap_u  [0:2];
   logic       done_n, err_n, to_n, adv, to_hit;
   logic [1:0] fld;
   int         fmax, d, tv, uv;

   function automatic logic [5:0] to_bin(logic [3:0] t, logic [3:0] u);
      return {2'b00, t} * 6'd10 + {2'b00, u};
   endfunction

`ifdef TIME_ENTRY_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] idle_cnt;
   assign to_hit = (state == EDIT) && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (rst || state != EDIT || bus.start || bus.key_valid ||
          bus.next || bus.back)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + CW'(1);
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_n = state;
      cur_n   = cur;
      tens_n  = tens;
      units_n = units;
      done_n  = 1'b0;
      err_n   = 1'b0;
      to_n    = 1'b0;
      adv     = 1'b0;
      fld     = cur[2:1];
      fmax    = (fld == 2'd0) ? HOUR_MAX : MIN_MAX;
      d       = int'(bus.key_val);
      tv      = int'(tens[fld]);
      uv      = int'(units[fld]);
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               tens_n[0]  = 4'(bus.cur_hour / 6'd10);
               units_n[0] = 4'(bus.cur_hour % 6'd10);
               tens_n[1]  = 4'(bus.cur_minute / 6'd10);
               units_n[1] = 4'(bus.cur_minute % 6'd10);
               tens_n[2]  = 4'(bus.cur_second / 6'd10);
               units_n[2] = 4'(bus.cur_second % 6'd10);
               cur_n      = 3'd0;
               state_n    = EDIT;
            end
         end
         EDIT: begin
            if (bus.abort) begin
               tens_n  = snap_t;
               units_n = snap_u;
               cur_n   = 3'd0;
               state_n = IDLE;
            end else if (bus.key_valid) begin
               if (d > 9) begin
                  err_n = 1'b1;
               end else if (!cur[0]) begin
                  if (d <= fmax / 10) begin
                     tens_n[fld] = bus.key_val;
                     // new tens may push the old units out of range
                     if (d * 10 + uv > fmax) units_n[fld] = 4'd0;
                     cur_n = cur + 3'd1;
                  end else begin
                     err_n = 1'b1;
                  end
               end else if (tv * 10 + d <= fmax) begin
                  units_n[fld] = bus.key_val;
                  adv          = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end else if (bus.next) begin
               adv = 1'b1;
            end else if (bus.back) begin
               if (cur != 3'd0) cur_n = cur - 3'd1;
            end else if (to_hit) begin
               tens_n  = snap_t;
               units_n = snap_u;
               cur_n   = 3'd0;
               state_n = IDLE;
               to_n    = 1'b1;
            end
            if (adv) begin
               if (cur == LAST) begin
                  done_n  = 1'b1;
                  cur_n   = 3'd0;
                  state_n = IDLE;
               end else begin
                  cur_n = cur + 3'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cur   <= 3'd0;
         for (int i = 0; i < 3; i++) begin
            tens[i]   <= 4'd0;
            units[i]  <= 4'd0;
            snap_t[i] <= 4'd0;
            snap_u[i] <= 4'd0;
         end
         bus.hour    <= 6'd0;
         bus.minute  <= 6'd0;
         bus.second  <= 6'd0;
         bus.twinkle <= 3'd0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
         bus.timeout <= 1'b0;
      end else begin
         state <= state_n;
         cur   <= cur_n;
         tens  <= tens_n;
         units <= units_n;
         if (state == IDLE && bus.start) begin
            snap_t <= tens_n;
            snap_u <= units_n;
         end
         bus.hour    <= to_bin(tens_n[0], units_n[0]);
         bus.minute  <= to_bin(tens_n[1], units_n[1]);
         bus.second  <= (NUM_FIELDS == 3) ?
                        to_bin(tens_n[2], units_n[2]) : 6'd0;
         bus.twinkle <= cur_n;
         bus.busy    <= (state_n == EDIT);
         bus.done    <= done_n;
         bus.err     <= err_n;
         bus.timeout <= to_n;
      end
   end
endmodule

// File: tb/tb_time_entry_ctrl.sv
// Scoreboard bench for time_entry_ctrl: two instances (2 and 3 fields) share stimulus.
// A value-level reference model queues expectations; a monitor pops and compares.
module tb_time_entry_ctrl;
   localparam int HMAX = 23;
   localparam int MMAX = 59;
   localparam int TC   = 8;

   typedef struct packed {
      logic [5:0] hour;
      logic [5:0] minute;
      logic [5:0] second;
      logic [2:0] twinkle;
      logic       busy;
      logic       done;
      logic       err;
      logic       timeout;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   time_entry_ctrl_if b0 ();
   time_entry_ctrl_if b1 ();

   time_entry_ctrl #(
      .NUM_FIELDS(2), .HOUR_MAX(HMAX), .MIN_MAX(MMAX), .TIMEOUT_CYCLES(TC)
   ) u0 (.clk(clk), .rst(rst), .bus(b0));

   time_entry_ctrl #(
      .NUM_FIELDS(3), .HOUR_MAX(HMAX), .MIN_MAX(MMAX), .TIMEOUT_CYCLES(TC)
   ) u1 (.clk(clk), .rst(rst), .bus(b1));

   obs_t q0[$];
   obs_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   ch = 0, cm = 0, cs = 0;

   bit m_edit [2];
   int m_v    [2][3];
   int m_snap [2][3];
   int m_pos  [2];
   int m_cnt  [2];

   function automatic string fmt(obs_t o);
      return $sformatf("%0d:%0d:%0d tw=%0d busy=%0b done=%0b err=%0b to=%0b",
                       o.hour, o.minute, o.second, o.twinkle,
                       o.busy, o.done, o.err, o.timeout);
   endfunction

   function automatic void restore(int k);
      for (int i = 0; i < 3; i++) m_v[k][i] = m_snap[k][i];
      m_edit[k] = 1'b0;
      m_pos[k]  = 0;
   endfunction

   function automatic obs_t mstep(int k, bit r, bit s, bit kv, int kval,
                                  bit nx, bit bk, bit ab);
      obs_t o;
      int nf, last, f, fm, v;
      bit adv, fire;
      o = '0;
      nf = (k == 0) ? 2 : 3;
      last = 2 * nf - 1;
      adv = 1'b0;
      fire = 1'b0;
      if (r) begin
         for (int i = 0; i < 3; i++) begin
            m_v[k][i] = 0;
            m_snap[k][i] = 0;
         end
         m_edit[k] = 1'b0;
         m_pos[k] = 0;
         m_cnt[k] = 0;
      end else if (!m_edit[k]) begin
         if (s) begin
            m_v[k][0] = ch; m_v[k][1] = cm; m_v[k][2] = cs;
            m_snap[k][0] = ch; m_snap[k][1] = cm; m_snap[k][2] = cs;
            m_pos[k] = 0;
            m_edit[k] = 1'b1;
         end
         m_cnt[k] = 0;
      end else begin
         f = m_pos[k] / 2;
         fm = (f == 0) ? HMAX : MMAX;
         v = m_v[k][f];
`ifdef TIME_ENTRY_TIMEOUT_EN
         fire = (m_cnt[k] == TC - 1);
`endif
         if (ab) begin
            restore(k);
         end else if (kv) begin
            if (kval > 9) o.err = 1'b1;
            else if (m_pos[k] % 2 == 0) begin
               if (kval <= fm / 10) begin
                  v = kval * 10 + v % 10;
                  if (v > fm) v = kval * 10;
                  m_v[k][f] = v;
                  m_pos[k]++;
               end else o.err = 1'b1;
            end else if ((v / 10) * 10 + kval <= fm) begin
               m_v[k][f] = (v / 10) * 10 + kval;
               adv = 1'b1;
            end else o.err = 1'b1;
         end else if (nx) begin
            adv = 1'b1;
         end else if (bk) begin
            if (m_pos[k] > 0) m_pos[k]--;
         end else if (fire) begin
            restore(k);
            o.timeout = 1'b1;
         end
         if (adv) begin
            if (m_pos[k] == last) begin
               o.done = 1'b1;
               m_edit[k] = 1'b0;
               m_pos[k] = 0;
            end else m_pos[k]++;
         end
         m_cnt[k] = (s || kv || nx || bk) ? 0 : m_cnt[k] + 1;
      end
      o.hour    = 6'(m_v[k][0]);
      o.minute  = 6'(m_v[k][1]);
      o.second  = (nf == 3) ? 6'(m_v[k][2]) : 6'd0;
      o.twinkle = 3'(m_pos[k]);
      o.busy    = m_edit[k];
      return o;
   endfunction

   task automatic set_in(bit r, bit s, bit kv, int kval, bit nx, bit bk, bit ab);
      rst = r;
      b0.start = s; b1.start = s;
      b0.cur_hour = 6'(ch); b1.cur_hour = 6'(ch);
      b0.cur_minute = 6'(cm); b1.cur_minute = 6'(cm);
      b0.cur_second = 6'(cs); b1.cur_second = 6'(cs);
      b0.key_valid = kv; b1.key_valid = kv;
      b0.key_val = 4'(kval); b1.key_val = 4'(kval);
      b0.next = nx; b1.next = nx;
      b0.back = bk; b1.back = bk;
      b0.abort = ab; b1.abort = ab;
   endtask

   task automatic drive(bit r, bit s, bit kv, int kval, bit nx, bit bk, bit ab);
      set_in(r, s, kv, kval, nx, bk, ab);
      q0.push_back(mstep(0, r, s, kv, kval, nx, bk, ab));
      q1.push_back(mstep(1, r, s, kv, kval, nx, bk, ab));
      @(negedge clk);
   endtask

   task automatic idle();  drive(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic start(); drive(0, 1, 0, 0, 0, 0, 0); endtask
   task automatic key(int d); drive(0, 0, 1, d, 0, 0, 0); endtask
   task automatic nxt();   drive(0, 0, 0, 0, 1, 0, 0); endtask
   task automatic bck();   drive(0, 0, 0, 0, 0, 1, 0); endtask
   task automatic abt();   drive(0, 0, 0, 0, 0, 0, 1); endtask

   task automatic chk(string nm, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            g = {b0.hour, b0.minute, b0.second, b0.twinkle,
                 b0.busy, b0.done, b0.err, b0.timeout};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL dut0 t=%0t got %s expected %s", $time, fmt(g), fmt(e));
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            g = {b1.hour, b1.minute, b1.second, b1.twinkle,
                 b1.busy, b1.done, b1.err, b1.timeout};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL dut1 t=%0t got %s expected %s", $time, fmt(g), fmt(e));
            end
         end
      end
   end

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("reset hour", b0.hour, 0);
      chk("reset busy", b0.busy, 0);

      ch = 12; cm = 34;
      start();
      chk("basic busy", b0.busy, 1);
      chk("basic tw0", b0.twinkle, 0);
      key(0); chk("basic tw1", b0.twinkle, 1);
      key(9); chk("basic tw2", b0.twinkle, 2);
      key(4); chk("basic tw3", b0.twinkle, 3);
      key(5);
      chk("basic done", b0.done, 1);
      chk("basic hour", b0.hour, 9);
      chk("basic minute", b0.minute, 45);
      chk("basic busy0", b0.busy, 0);

      abt(); start();
      key(3); chk("range err3", b0.err, 1); chk("range tw", b0.twinkle, 0);
      key(2); key(5); chk("range err25", b0.err, 1);
      key(3); chk("range hour23", b0.hour, 23);
      abt();
      ch = 19; start(); key(2); chk("range clear", b0.hour, 20);

      abt(); ch = 8; cm = 15; start();
      nxt(); nxt(); key(4); chk("nav minute", b0.minute, 45);
      bck(); bck(); chk("nav tw", b0.twinkle, 1);
      abt();
      chk("nav hour", b0.hour, 8);
      chk("nav minute back", b0.minute, 15);
      chk("nav no done", b0.done, 0);

      abt(); ch = 0; cm = 0; cs = 0; start();
      key(1); key(2); key(3); key(0); key(5); key(9);
      chk("f3 done", b1.done, 1);
      chk("f3 hour", b1.hour, 12);
      chk("f3 minute", b1.minute, 30);
      chk("f3 second", b1.second, 59);
      start(); nxt(); nxt(); nxt(); nxt();
      key(6); chk("f3 sec tens err", b1.err, 1);

      abt(); ch = 12; cm = 34; start();
      drive(0, 0, 1, 1, 1, 0, 0); chk("sim tw", b0.twinkle, 1);
      key(12); chk("sim err", b0.err, 1); chk("sim tw hold", b0.twinkle, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("rst hour", b0.hour, 0); chk("rst busy", b0.busy, 0);

`ifdef TIME_ENTRY_TIMEOUT_EN
      ch = 12; cm = 34; start(); key(0);
      repeat (8) idle();
      chk("timeout pulse", b0.timeout, 1);
      chk("timeout hour", b0.hour, 12);
      start();
      repeat (6) idle();
      key(1); idle();
      chk("timeout held off", b0.timeout, 0);
      chk("timeout busy", b0.busy, 1);
`endif

      repeat (4000) begin
         int kv_r;
         ch = $urandom_range(0, HMAX);
         cm = $urandom_range(0, MMAX);
         cs = $urandom_range(0, MMAX);
         kv_r = ($urandom % 5 == 0) ? 10 + $urandom % 6 : $urandom % 10;
         drive($urandom % 400 == 0, $urandom % 6 == 0, $urandom % 3 == 0,
               kv_r, $urandom % 8 == 0, $urandom % 10 == 0,
               $urandom % 60 == 0);
      end
      idle();
      chk("queue drained", q0.size() + q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
